// File: rtl/debug_frame_tx.sv
// Purpose: snapshot PC/cycles, sweep registers and memory, stream a checksummed byte frame to the UART.
// Latency: SOF issued 1 cycle after an accepted i_start; 1 cycle per byte turnaround, 3 across a debug read.
// Backpressure: one byte in flight, the next waits for i_tx_done; i_start is dropped while busy.
module debug_frame_tx #(
   parameter int         NB_DATA     = 32,
   parameter int         N_REGS      = 32,
   parameter int         NB_REG      = 5,
   parameter int         N_MEM       = 32,
   parameter int         NB_MEM_ADDR = 5,
   parameter bit         MSB_FIRST   = 1'b1,
   parameter logic [7:0] SOF         = 8'hA5
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_start,
   input  logic [NB_DATA-1:0]     i_pc,
   input  logic [NB_DATA-1:0]     i_cycles,
   output logic                   o_reg_rd,
   output logic [NB_REG-1:0]      o_reg_addr,
   input  logic [NB_DATA-1:0]     i_reg_data,
   output logic                   o_mem_rd,
   output logic [NB_MEM_ADDR-1:0] o_mem_addr,
   input  logic [NB_DATA-1:0]     i_mem_data,
   input  logic                   i_mem_dirty,
   output logic [7:0]             o_tx_data,
   output logic                   o_tx_start,
   input  logic                   i_tx_done,
   output logic                   o_busy,
   output logic                   o_done
);

   localparam int B     = NB_DATA / 8;
   localparam int BW    = (B > 1) ? $clog2(B) : 1;
   localparam int N_MAX = (N_REGS > N_MEM) ? N_REGS : N_MEM;
   localparam int IW    = (N_MAX > 1) ? $clog2(N_MAX) : 1;
   localparam logic [BW-1:0] BYTE_LAST = BW'(B - 1);
   localparam logic [IW-1:0] REG_LAST  = IW'(N_REGS - 1);
   localparam logic [IW-1:0] MEM_LAST  = IW'(N_MEM - 1);

   typedef enum logic [3:0] {
      ST_IDLE, ST_SOF, ST_PC, ST_CYC, ST_REG_RD, ST_REG_TX,
      ST_MEM_RD, ST_MEM_FLAG, ST_MEM_TX, ST_CSUM, ST_DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [NB_DATA-1:0]     pc_q, pc_d, cyc_q, cyc_d, sh_q, sh_d;
   logic [7:0]             csum_q, csum_d, tx_data_q, tx_data_d;
   logic [BW-1:0]          byte_q, byte_d;
   logic [IW-1:0]          idx_q, idx_d, idx_inc;
   logic                   dirty_q, dirty_d;
   logic                   tx_start_q, tx_start_d, reg_rd_q, reg_rd_d, mem_rd_q, mem_rd_d;
   logic                   busy_q, busy_d, done_q, done_d;
   logic [NB_REG-1:0]      reg_addr_q, reg_addr_d;
   logic [NB_MEM_ADDR-1:0] mem_addr_q, mem_addr_d;

   logic                   last_byte, send, add_csum, word_new, word_next, mem_next;
   logic [7:0]             send_byte;
   logic [NB_DATA-1:0]     word_src;

   // First byte of a word on the wire, honouring the configured byte order
   function automatic logic [7:0] first_byte(input logic [NB_DATA-1:0] w);
      return MSB_FIRST ? w[NB_DATA-1 -: 8] : w[7:0];
   endfunction

   // Word with its first byte consumed
   function automatic logic [NB_DATA-1:0] shift_word(input logic [NB_DATA-1:0] w);
      return MSB_FIRST ? (w << 8) : (w >> 8);
   endfunction

   assign last_byte = (byte_q == BYTE_LAST);
   assign idx_inc   = idx_q + IW'(1);

   // State register and all datapath/output flops
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         pc_q       <= '0;
         cyc_q      <= '0;
         sh_q       <= '0;
         csum_q     <= '0;
         tx_data_q  <= '0;
         byte_q     <= '0;
         idx_q      <= '0;
         dirty_q    <= 1'b0;
         tx_start_q <= 1'b0;
         reg_rd_q   <= 1'b0;
         mem_rd_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         reg_addr_q <= '0;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         cyc_q      <= cyc_d;
         sh_q       <= sh_d;
         csum_q     <= csum_d;
         tx_data_q  <= tx_data_d;
         byte_q     <= byte_d;
         idx_q      <= idx_d;
         dirty_q    <= dirty_d;
         tx_start_q <= tx_start_d;
         reg_rd_q   <= reg_rd_d;
         mem_rd_q   <= mem_rd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         reg_addr_q <= reg_addr_d;
         mem_addr_q <= mem_addr_d;
      end
   end

   // Next state: TX states advance on i_tx_done, read states on the capture cycle (strobe already low)
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (i_start) state_d = ST_SOF;
         ST_SOF:      if (i_tx_done) state_d = ST_PC;
         ST_PC:       if (i_tx_done && last_byte) state_d = ST_CYC;
         ST_CYC:      if (i_tx_done && last_byte) state_d = ST_REG_RD;
         ST_REG_RD:   if (!reg_rd_q) state_d = ST_REG_TX;
         ST_REG_TX:   if (i_tx_done && last_byte) state_d = (idx_q == REG_LAST) ? ST_MEM_RD : ST_REG_RD;
         ST_MEM_RD:   if (!mem_rd_q) state_d = ST_MEM_FLAG;
         ST_MEM_FLAG: if (i_tx_done) state_d = dirty_q ? ST_MEM_TX : ((idx_q == MEM_LAST) ? ST_CSUM : ST_MEM_RD);
         ST_MEM_TX:   if (i_tx_done && last_byte) state_d = (idx_q == MEM_LAST) ? ST_CSUM : ST_MEM_RD;
         ST_CSUM:     if (i_tx_done) state_d = ST_DONE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Outputs and datapath: issue bytes, shift words, strobe reads, accumulate the checksum
   always_comb begin
      pc_d       = pc_q;
      cyc_d      = cyc_q;
      sh_d       = sh_q;
      csum_d     = csum_q;
      tx_data_d  = tx_data_q;
      byte_d     = byte_q;
      idx_d      = idx_q;
      dirty_d    = dirty_q;
      reg_addr_d = reg_addr_q;
      mem_addr_d = mem_addr_q;
      busy_d     = busy_q;
      tx_start_d = 1'b0;
      reg_rd_d   = 1'b0;
      mem_rd_d   = 1'b0;
      done_d     = 1'b0;
      send       = 1'b0;
      send_byte  = 8'h00;
      add_csum   = 1'b1;
      word_new   = 1'b0;
      word_next  = 1'b0;
      word_src   = '0;
      mem_next   = 1'b0;
      case (state_q)
         ST_IDLE: if (i_start) begin
            pc_d      = i_pc;
            cyc_d     = i_cycles;
            csum_d    = 8'h00;
            busy_d    = 1'b1;
            send      = 1'b1;
            send_byte = SOF;
            add_csum  = 1'b0;
         end
         ST_SOF: if (i_tx_done) begin
            word_new = 1'b1;
            word_src = pc_q;
         end
         ST_PC: if (i_tx_done) begin
            if (last_byte) begin
               word_new = 1'b1;
               word_src = cyc_q;
            end else begin
               word_next = 1'b1;
            end
         end
         ST_CYC: if (i_tx_done) begin
            if (last_byte) begin
               reg_rd_d   = 1'b1;
               reg_addr_d = '0;
               idx_d      = '0;
            end else begin
               word_next = 1'b1;
            end
         end
         ST_REG_RD: if (!reg_rd_q) begin
            word_new = 1'b1;
            word_src = i_reg_data;
         end
         ST_REG_TX: if (i_tx_done) begin
            if (!last_byte) begin
               word_next = 1'b1;
            end else if (idx_q == REG_LAST) begin
               idx_d      = '0;
               mem_rd_d   = 1'b1;
               mem_addr_d = '0;
            end else begin
               idx_d      = idx_inc;
               reg_rd_d   = 1'b1;
               reg_addr_d = NB_REG'(idx_inc);
            end
         end
         ST_MEM_RD: if (!mem_rd_q) begin
            send      = 1'b1;
            send_byte = {7'b0, i_mem_dirty};
            sh_d      = i_mem_data;
            dirty_d   = i_mem_dirty;
         end
         ST_MEM_FLAG: if (i_tx_done) begin
            if (dirty_q) begin
               word_new = 1'b1;
               word_src = sh_q;
            end else begin
               mem_next = 1'b1;
            end
         end
         ST_MEM_TX: if (i_tx_done) begin
            if (!last_byte) word_next = 1'b1;
            else            mem_next  = 1'b1;
         end
         ST_CSUM: if (i_tx_done) begin
            done_d = 1'b1;
            busy_d = 1'b0;
         end
         default: ;
      endcase
      if (word_new) begin
         send      = 1'b1;
         send_byte = first_byte(word_src);
         sh_d      = shift_word(word_src);
         byte_d    = '0;
      end
      if (word_next) begin
         send      = 1'b1;
         send_byte = first_byte(sh_q);
         sh_d      = shift_word(sh_q);
         byte_d    = byte_q + BW'(1);
      end
      // After the last memory entry the checksum goes out; it is not folded into itself
      if (mem_next) begin
         if (idx_q == MEM_LAST) begin
            send      = 1'b1;
            send_byte = csum_q;
            add_csum  = 1'b0;
         end else begin
            idx_d      = idx_inc;
            mem_rd_d   = 1'b1;
            mem_addr_d = NB_MEM_ADDR'(idx_inc);
         end
      end
      if (send) begin
         tx_start_d = 1'b1;
         tx_data_d  = send_byte;
         if (add_csum) csum_d = csum_q ^ send_byte;
      end
   end

   assign o_tx_data  = tx_data_q;
   assign o_tx_start = tx_start_q;
   assign o_reg_rd   = reg_rd_q;
   assign o_reg_addr = reg_addr_q;
   assign o_mem_rd   = mem_rd_q;
   assign o_mem_addr = mem_addr_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;

endmodule

// File: tb/tb_debug_frame_tx.sv
// Bench for debug_frame_tx: two instances (MSB-first and LSB-first) share stimulus,
// each with its own register/memory read model and UART model (done 10 cycles after start).
// Expected bytes are queued per instance when a frame is requested and popped as bytes appear.
module tb_debug_frame_tx;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_start;
   logic [15:0] i_pc;
   logic [15:0] i_cycles;
   logic        spur;

   wire [1:0]      busy, done, tx_start, reg_rd, mem_rd, reg_addr, mem_addr;
   wire [1:0][7:0] tx_data;

   logic [15:0] regs_m  [2];
   logic [15:0] mem_m   [2];
   logic        dirty_m [2];

   logic [7:0] exp0 [$];
   logic [7:0] exp1 [$];
   logic [7:0] csum;
   int         nb0 = 0;
   int         nb1 = 0;
   int         n_chk = 0;
   int         n_pass = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [15:0] rdat   = '0;
      logic [15:0] mdat   = '0;
      logic        mdirty = 1'b0;
      logic        udone  = 1'b0;
      int          ucnt   = 0;

      always @(posedge clk) begin
         if (reg_rd[g]) rdat <= regs_m[reg_addr[g]];
         if (mem_rd[g]) begin
            mdat   <= mem_m[mem_addr[g]];
            mdirty <= dirty_m[mem_addr[g]];
         end
         udone <= 1'b0;
         if (tx_start[g]) ucnt <= 10;
         else if (ucnt != 0) begin
            ucnt <= ucnt - 1;
            if (ucnt == 1) udone <= 1'b1;
         end
      end

      debug_frame_tx #(
         .NB_DATA(16), .N_REGS(2), .NB_REG(1), .N_MEM(2), .NB_MEM_ADDR(1),
         .MSB_FIRST(g == 0), .SOF(8'hA5)
      ) u_dut (
         .i_clock(clk), .i_reset(i_reset), .i_start(i_start),
         .i_pc(i_pc), .i_cycles(i_cycles),
         .o_reg_rd(reg_rd[g]), .o_reg_addr(reg_addr[g]), .i_reg_data(rdat),
         .o_mem_rd(mem_rd[g]), .o_mem_addr(mem_addr[g]),
         .i_mem_data(mdat), .i_mem_dirty(mdirty),
         .o_tx_data(tx_data[g]), .o_tx_start(tx_start[g]), .i_tx_done(udone | spur),
         .o_busy(busy[g]), .o_done(done[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] outs(input int d);
      return {17'b0, busy[d], done[d], tx_start[d], reg_rd[d], mem_rd[d],
              tx_data[d], reg_addr[d], mem_addr[d]};
   endfunction

   // Scoreboard side: every issued byte must match the head of its instance's queue
   task automatic monitor();
      int         have;
      logic [7:0] e;
      if (tx_start[0]) begin
         nb0++;
         have = exp0.size();
         if (have == 0) chk("unexpected_byte_msb", 32'(have), 32'd1);
         else begin
            e = exp0.pop_front();
            chk("byte_msb", {24'b0, tx_data[0]}, {24'b0, e});
         end
      end
      if (tx_start[1]) begin
         nb1++;
         have = exp1.size();
         if (have == 0) chk("unexpected_byte_lsb", 32'(have), 32'd1);
         else begin
            e = exp1.pop_front();
            chk("byte_lsb", {24'b0, tx_data[1]}, {24'b0, e});
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
   endtask

   task automatic push_raw(input logic [7:0] b);
      exp0.push_back(b);
      exp1.push_back(b);
   endtask

   task automatic push_sum(input logic [7:0] b);
      push_raw(b);
      csum = csum ^ b;
   endtask

   task automatic push_word(input logic [15:0] w);
      exp0.push_back(w[15:8]);
      exp0.push_back(w[7:0]);
      exp1.push_back(w[7:0]);
      exp1.push_back(w[15:8]);
      csum = csum ^ w[15:8] ^ w[7:0];
   endtask

   task automatic expect_frame(input logic [15:0] pc, input logic [15:0] cyc);
      csum = 8'h00;
      push_raw(8'hA5);
      push_word(pc);
      push_word(cyc);
      for (int r = 0; r < 2; r++) push_word(regs_m[r]);
      for (int m = 0; m < 2; m++) begin
         push_sum({7'b0, dirty_m[m]});
         if (dirty_m[m]) push_word(mem_m[m]);
      end
      push_raw(csum);
   endtask

   // One complete frame; optional drop injection (start + pc change) and spurious done during reads
   task automatic run_frame(input string tag, input logic [15:0] pc, input logic [15:0] cyc,
                            input int exp_len, input int drop_at, input bit spur_rd);
      int b0, b1, hold;
      bit busy_ok, seen, dropped;
      expect_frame(pc, cyc);
      b0 = nb0;
      b1 = nb1;
      i_pc = pc;
      i_cycles = cyc;
      chk({tag, "_busy_before"}, 32'(busy), 32'd0);
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      chk({tag, "_busy_rise"}, 32'(busy), 32'd3);
      chk({tag, "_sof_latency"}, 32'(nb0 - b0), 32'd1);
      busy_ok = 1'b1;
      seen = 1'b0;
      dropped = 1'b0;
      hold = 0;
      for (int c = 0; c < 2000 && !seen; c++) begin
         tick();
         i_start = 1'b0;
         if (spur_rd && (reg_rd[0] || mem_rd[0])) hold = 2;
         spur = (hold > 0);
         if (hold > 0) hold--;
         if (done[0]) begin
            seen = 1'b1;
            chk({tag, "_done_both"}, 32'(done), 32'd3);
            chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
            chk({tag, "_len_msb"}, 32'(nb0 - b0), 32'(exp_len));
            chk({tag, "_len_lsb"}, 32'(nb1 - b1), 32'(exp_len));
            chk({tag, "_queues_drained"}, 32'(exp0.size() + exp1.size()), 32'd0);
            if (drop_at >= 0) i_start = 1'b1;
         end else begin
            if (busy != 2'b11) busy_ok = 1'b0;
            if (drop_at >= 0 && !dropped && (nb0 - b0) == drop_at) begin
               i_pc = 16'hFFFF;
               i_start = 1'b1;
               dropped = 1'b1;
            end
         end
      end
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_busy_steady"}, 32'(busy_ok), 32'd1);
      spur = 1'b0;
      tick();
      i_start = 1'b0;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   initial begin
      int b0;
      i_reset = 1'b1;
      i_start = 1'b0;
      i_pc = '0;
      i_cycles = '0;
      spur = 1'b0;
      regs_m[0] = 16'h1234;  regs_m[1] = 16'h00FF;
      mem_m[0]  = 16'hABCD;  mem_m[1]  = 16'h5A5A;
      dirty_m[0] = 1'b1;     dirty_m[1] = 1'b0;

      repeat (3) @(negedge clk);
      chk("reset_outs_msb", outs(0), 32'd0);
      chk("reset_outs_lsb", outs(1), 32'd0);
      i_reset = 1'b0;
      tick();

      // Spurious done pulses while idle must not produce bytes
      b0 = nb0;
      spur = 1'b1; tick(); spur = 1'b0; tick();
      spur = 1'b1; tick(); spur = 1'b0;
      repeat (20) tick();
      chk("idle_spur_bytes", 32'(nb0 - b0), 32'd0);
      chk("idle_spur_busy", 32'(busy), 32'd0);

      run_frame("basic", 16'h0104, 16'h0009, 14, -1, 1'b0);

      dirty_m[0] = 1'b0;
      run_frame("all_clean", 16'h0104, 16'h0009, 12, -1, 1'b0);
      dirty_m[0] = 1'b1;

      // Start pulses mid-frame and in the done cycle are dropped; pc is snapshotted
      run_frame("drop", 16'h0104, 16'h0009, 14, 5, 1'b0);
      b0 = nb0;
      repeat (300) tick();
      chk("drop_no_second_frame", 32'(nb0 - b0), 32'd0);
      chk("drop_idle_busy", 32'(busy), 32'd0);

      run_frame("spur_reads", 16'h0104, 16'h0009, 14, -1, 1'b1);

      regs_m[0] = 16'hC3E1;  regs_m[1] = 16'h0F70;
      mem_m[0]  = 16'h8001;  mem_m[1]  = 16'h7EED;
      dirty_m[0] = 1'b1;     dirty_m[1] = 1'b1;
      run_frame("both_dirty", 16'hBEEF, 16'h2A5C, 16, -1, 1'b0);

      // Reset while the first memory data byte is in flight
      regs_m[0] = 16'h1234;  regs_m[1] = 16'h00FF;
      mem_m[0]  = 16'hABCD;  mem_m[1]  = 16'h5A5A;
      dirty_m[0] = 1'b1;     dirty_m[1] = 1'b0;
      expect_frame(16'h0104, 16'h0009);
      b0 = nb0;
      i_pc = 16'h0104;
      i_cycles = 16'h0009;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int c = 0; c < 1000 && (nb0 - b0) < 11; c++) tick();
      chk("rst_reached_memtx", 32'(nb0 - b0), 32'd11);
      repeat (3) tick();
      #1 i_reset = 1'b1;
      #1;
      chk("rst_outs_msb", outs(0), 32'd0);
      chk("rst_outs_lsb", outs(1), 32'd0);
      exp0.delete();
      exp1.delete();
      repeat (3) tick();
      i_reset = 1'b0;
      repeat (20) tick();
      chk("rst_no_partial", 32'(nb0 - b0), 32'd11);
      run_frame("after_reset", 16'h0104, 16'h0009, 14, -1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
